// File: rtl/key_debounce_irq_ctrl.sv
// Avalon-MM push-button controller: 2-FF sync, programmable debounce, edge capture and maskable IRQ.
// Optional press counter in DATA[31:16] is built when KEY_PRESS_COUNTER_EN is defined.
module key_debounce_irq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        irq,
    output logic        key_level
);

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] CHK_HI    = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] CHK_LO    = 2'd3;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_THRESH  = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // A programmed threshold of zero behaves like one cycle.
    function automatic logic [CNT_W-1:0] eff_thresh(input logic [CNT_W-1:0] t);
        return (t == '0) ? CNT_W'(1) : t;
    endfunction

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic [1:0]       mask_q, mask_d;
    logic [1:0]       edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             rise_evt, fall_evt;
    logic             wr_en;
    logic [1:0]       ec_clr;
    logic [CNT_W-1:0] thr_eff;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign thr_eff      = eff_thresh(thresh_q);
    assign unused_wdata = ^writedata[31:CNT_W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_evt = 1'b0;
        fall_evt = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (sync2_q) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_HI: begin
                if (!sync2_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q >= thr_eff) begin
                    state_d  = STABLE_HI;
                    cnt_d    = '0;
                    level_d  = 1'b1;
                    rise_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!sync2_q) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                if (sync2_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q >= thr_eff) begin
                    state_d  = STABLE_LO;
                    cnt_d    = '0;
                    level_d  = 1'b0;
                    fall_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Register writes; a capture event in the same cycle as its W1C clear wins.
    always_comb begin
        thresh_d = thresh_q;
        mask_d   = mask_q;
        ec_clr   = 2'b00;
        if (wr_en) begin
            case (address)
                ADDR_THRESH:  thresh_d = writedata[CNT_W-1:0];
                ADDR_MASK:    mask_d   = writedata[1:0];
                ADDR_EDGECAP: ec_clr   = writedata[1:0];
                default:      ;
            endcase
        end
        edgecap_d = (edgecap_q & ~ec_clr) | {fall_evt, rise_evt};
    end

`ifdef KEY_PRESS_COUNTER_EN
    logic [15:0] press_cnt_q, press_cnt_d;

    always_comb begin
        if (wr_en && address == ADDR_DATA) begin
            press_cnt_d = rise_evt ? 16'd1 : 16'd0;
        end else begin
            press_cnt_d = press_cnt_q + {15'd0, rise_evt};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_cnt_q <= 16'd0;
        end else begin
            press_cnt_q <= press_cnt_d;
        end
    end
`endif

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: begin
                readdata_d[0] = level_q;
`ifdef KEY_PRESS_COUNTER_EN
                readdata_d[31:16] = press_cnt_q;
`endif
            end
            ADDR_THRESH:  readdata_d[CNT_W-1:0] = thresh_q;
            ADDR_MASK:    readdata_d[1:0]       = mask_q;
            default:      readdata_d[1:0]       = edgecap_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= STABLE_LO;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            thresh_q   <= CNT_W'(DEBOUNCE_CYCLES);
            mask_q     <= 2'b00;
            edgecap_q  <= 2'b00;
            readdata_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            thresh_q   <= thresh_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata  = readdata_q;
    assign key_level = level_q;
    assign irq       = |(edgecap_q & mask_q);

endmodule
